wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Debug/observability block downstream of the pipelined MIPS core's write-back stage. Captures every architectural register write-back (destination, data, sequence number) into a small FIFO drained by a valid/ready consumer, and keeps free-running performance counters (cycles, stalls, retired writes, taken branches, dropped entries). It is purely an observer and never back-pressures the core.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- SEQ_W, 16: sequence-number width.
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high; clears all state.
- ip_clear  in  1  synchronous clear of FIFO, counters, sequence, overflow.
- ip_RegWrite_WB  in  1  write-back register-write enable from core.
- ip_dest_WB  in  5  write-back destination register.
- ip_write_data_WB  in  32  write-back data.
- ip_stall  in  1  hazard stall flag from core.
- ip_branch  in  1  branch flag in EX.
- ip_zero  in  1  ALU zero flag in EX.
- ip_trace_ready  in  1  consumer accepts head entry.
- op_trace_valid  out  1  FIFO non-empty; head entry valid.
- op_trace_seq  out  SEQ_W  head entry sequence number.
- op_trace_dest  out  5  head entry destination.
- op_trace_data  out  32  head entry data.
- op_fill  out  $clog2(DEPTH)+1  current occupancy.
- op_overflow  out  1  sticky: at least one event dropped.
- op_cycle_count, op_stall_count, op_retire_count, op_branch_count, op_drop_count  out  32 each  counters.

## Operation
- Event = ip_RegWrite_WB && ip_dest_WB != 0. Writes to $0 are not events and are not counted.
- Every event gets the current sequence value, then sequence increments (wraps at 2^SEQ_W), whether the entry is stored or dropped; gaps in op_trace_seq reveal drops.
- Push on event when not full, or when full with a pop in the same cycle.
- Full, event, no pop: entry dropped; op_drop_count++, op_overflow set until clear/reset.
- Pop when op_trace_valid && ip_trace_ready. ip_trace_ready while empty is ignored.
- Empty with push: no bypass; entry is visible next cycle.
- Counters (all wrap modulo 2^32): cycle +1 every cycle; stall +1 when ip_stall; retire +1 per event (including dropped); branch +1 when ip_branch && ip_zero.
- ip_clear has priority: FIFO emptied, all counters, sequence, and overflow zeroed; an event in the clear cycle is discarded and not counted. cycle_count reads 1 the cycle after clear.
- Head outputs hold stable while op_trace_valid && !ip_trace_ready.

## Timing
- Reset: every output 0; FIFO empty.
- Event in cycle N into empty FIFO: op_trace_valid=1 and head fields valid in cycle N+1.
- Pop in cycle N: next entry (or valid=0) in cycle N+1.
- op_fill updates one cycle after push/pop; a simultaneous push and pop leaves it unchanged.
- Counters are registered; the increment from cycle N is visible in N+1.
- Reset asserted mid-drain: outputs drop to 0 asynchronously; the entry being popped is lost.
- Pointers are $clog2(DEPTH) bits with an extra wrap bit; full = MSBs differ and LSBs equal.

## Structure
- Package trace_pkg: trace_entry_t packed struct {seq[SEQ_W], dest[5], data[32]}, DEPTH/SEQ_W defaults, COUNT_W=32.
- Sub-module trace_fifo: synchronous FIFO of trace_entry_t with push, pop, full, empty, fill, and sync clear. wb_trace_buffer holds the event qualification, sequence, counters, and overflow.

## Test plan
- Reset, then 3 events ($1=0x11, $2=0x22, $3=0x33) with ready=1: outputs seq 0,1,2 in order, each one cycle after its event; fill returns to 0.
- Event to $0 with data 0xDEAD: no entry, retire_count stays 0, seq stays 0.
- ready=0, DEPTH+2 events: fill=DEPTH, drop_count=2, overflow=1. Drain shows seq 0..7; the next event after drain carries seq 10.
- Full FIFO with event and pop in the same cycle: no drop, fill stays DEPTH, new entry lands at tail.
- 10 cycles with stall on cycles 3–5 and branch&zero on cycle 7: stall_count=3, branch_count=1, cycle_count=10. ip_clear concurrent with an event: all counters 0, FIFO empty, overflow 0.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared entry type and defaults for the write-back trace buffer
package trace_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_SEQ_W = 16;
  localparam int COUNT_W = 32;
  typedef struct packed {
    logic [DEF_SEQ_W-1:0] seq;
    logic [4:0]           dest;
    logic [31:0]          data;
  } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of trace entries with sync clear
//   clk/rst (async, active-high), clear (sync flush), push/pop (pre-qualified by caller),
//   wr_entry -> tail, rd_entry = head (0 when empty), full/empty/fill status
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wr_entry,
  output entry_t                 rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = clear ? '0 : wr_q + (AW+1)'(push);
    rd_d = clear ? '0 : rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_q[AW-1:0]] <= wr_entry;
  // extra wrap bit distinguishes full from empty when the index bits match
  assign empty    = wr_q == rd_q;
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign fill     = wr_q - rd_q;
  // gate the head so stale memory never shows while empty (incl. right after reset)
  assign rd_entry = empty ? '0 : mem[rd_q[AW-1:0]];
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: write-back trace FIFO plus free-running performance counters
//   clock/reset (async, active-high), ip_clear (sync clear of everything)
//   ip_RegWrite_WB/ip_dest_WB/ip_write_data_WB: core write-back; ip_stall/ip_branch/ip_zero: counter events
//   ip_trace_ready/op_trace_*: valid/ready head of trace FIFO; op_fill, op_overflow, op_*_count: status
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ip_clear,
  input  logic                   ip_RegWrite_WB,
  input  logic [4:0]             ip_dest_WB,
  input  logic [31:0]            ip_write_data_WB,
  input  logic                   ip_stall,
  input  logic                   ip_branch,
  input  logic                   ip_zero,
  input  logic                   ip_trace_ready,
  output logic                   op_trace_valid,
  output logic [SEQ_W-1:0]       op_trace_seq,
  output logic [4:0]             op_trace_dest,
  output logic [31:0]            op_trace_data,
  output logic [$clog2(DEPTH):0] op_fill,
  output logic                   op_overflow,
  output logic [COUNT_W-1:0]     op_cycle_count,
  output logic [COUNT_W-1:0]     op_stall_count,
  output logic [COUNT_W-1:0]     op_retire_count,
  output logic [COUNT_W-1:0]     op_branch_count,
  output logic [COUNT_W-1:0]     op_drop_count
);
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [4:0]       dest;
    logic [31:0]      data;
  } entry_t;
  entry_t wr_entry, head;
  logic full, empty, ev, push, pop, drop;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic ovf_q, ovf_d;
  logic [COUNT_W-1:0] cyc_q, cyc_d, stl_q, stl_d, ret_q, ret_d, br_q, br_d, drp_q, drp_d;
  always_comb begin
    ev       = ip_RegWrite_WB && (ip_dest_WB != 5'd0) && !ip_clear;
    pop      = !empty && ip_trace_ready && !ip_clear;
    push     = ev && (!full || pop);
    drop     = ev && !push;
    wr_entry = '{seq: seq_q, dest: ip_dest_WB, data: ip_write_data_WB};
    seq_d    = ip_clear ? '0 : seq_q + SEQ_W'(ev);
    ovf_d    = !ip_clear && (ovf_q || drop);
    // the clear cycle itself is the first counted cycle
    cyc_d    = ip_clear ? COUNT_W'(1) : cyc_q + COUNT_W'(1);
    stl_d    = ip_clear ? '0 : stl_q + COUNT_W'(ip_stall);
    ret_d    = ip_clear ? '0 : ret_q + COUNT_W'(ev);
    br_d     = ip_clear ? '0 : br_q + COUNT_W'(ip_branch && ip_zero);
    drp_d    = ip_clear ? '0 : drp_q + COUNT_W'(drop);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      seq_q <= '0;
      ovf_q <= 1'b0;
      cyc_q <= '0;
      stl_q <= '0;
      ret_q <= '0;
      br_q  <= '0;
      drp_q <= '0;
    end else begin
      seq_q <= seq_d;
      ovf_q <= ovf_d;
      cyc_q <= cyc_d;
      stl_q <= stl_d;
      ret_q <= ret_d;
      br_q  <= br_d;
      drp_q <= drp_d;
    end
  trace_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(clock), .rst(reset), .clear(ip_clear), .push(push), .pop(pop),
    .wr_entry(wr_entry), .rd_entry(head), .full(full), .empty(empty), .fill(op_fill)
  );
  assign op_trace_valid  = !empty;
  assign op_trace_seq    = head.seq;
  assign op_trace_dest   = head.dest;
  assign op_trace_data   = head.data;
  assign op_overflow     = ovf_q;
  assign op_cycle_count  = cyc_q;
  assign op_stall_count  = stl_q;
  assign op_retire_count = ret_q;
  assign op_branch_count = br_q;
  assign op_drop_count   = drp_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: randomized scoreboard bench for wb_trace_buffer against a queue-based model
module tb_wb_trace_buffer;
  localparam int DEPTH = 8;
  localparam int SEQ_W = 16;
  localparam int FW = $clog2(DEPTH) + 1;
  logic clock = 1'b0, reset = 1'b1;
  logic ip_clear = 0, ip_RegWrite_WB = 0, ip_stall = 0, ip_branch = 0, ip_zero = 0, ip_trace_ready = 0;
  logic [4:0] ip_dest_WB = '0;
  logic [31:0] ip_write_data_WB = '0;
  logic op_trace_valid, op_overflow;
  logic [SEQ_W-1:0] op_trace_seq;
  logic [4:0] op_trace_dest;
  logic [31:0] op_trace_data;
  logic [FW-1:0] op_fill;
  logic [31:0] op_cycle_count, op_stall_count, op_retire_count, op_branch_count, op_drop_count;
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [4:0]       dest;
    logic [31:0]      data;
  } exp_t;
  exp_t exp_q[$];
  int unsigned m_cyc, m_stl, m_ret, m_br, m_drp, m_seq;
  bit m_ovf;
  int n_chk = 0, n_fail = 0;

  wb_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clock(clock), .reset(reset), .ip_clear(ip_clear), .ip_RegWrite_WB(ip_RegWrite_WB),
    .ip_dest_WB(ip_dest_WB), .ip_write_data_WB(ip_write_data_WB), .ip_stall(ip_stall),
    .ip_branch(ip_branch), .ip_zero(ip_zero), .ip_trace_ready(ip_trace_ready),
    .op_trace_valid(op_trace_valid), .op_trace_seq(op_trace_seq), .op_trace_dest(op_trace_dest),
    .op_trace_data(op_trace_data), .op_fill(op_fill), .op_overflow(op_overflow),
    .op_cycle_count(op_cycle_count), .op_stall_count(op_stall_count),
    .op_retire_count(op_retire_count), .op_branch_count(op_branch_count),
    .op_drop_count(op_drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cyc = 0; m_stl = 0; m_ret = 0; m_br = 0; m_drp = 0; m_seq = 0; m_ovf = 0;
  endtask

  task automatic check_state();
    check("cycle_count", op_cycle_count, m_cyc);
    check("stall_count", op_stall_count, m_stl);
    check("retire_count", op_retire_count, m_ret);
    check("branch_count", op_branch_count, m_br);
    check("drop_count", op_drop_count, m_drp);
    check("overflow", {31'd0, op_overflow}, {31'd0, m_ovf});
    check("fill", {{(32-FW){1'b0}}, op_fill}, exp_q.size());
  endtask

  // one clock cycle of stimulus; the model decides store/drop from current occupancy
  task automatic step(input bit we = 0, input logic [4:0] d = '0, input logic [31:0] dat = '0,
                      input bit rdy = 0, input bit st = 0, input bit b = 0, input bit z = 0,
                      input bit clr = 0);
    bit ev, pop, store;
    ip_RegWrite_WB = we; ip_dest_WB = d; ip_write_data_WB = dat;
    ip_trace_ready = rdy && !clr; ip_stall = st; ip_branch = b; ip_zero = z; ip_clear = clr;
    ev    = we && (d != 0);
    pop   = (exp_q.size() > 0) && rdy;
    store = ev && ((exp_q.size() < DEPTH) || pop);
    @(posedge clock);
    if (clr) begin
      model_reset();
      m_cyc = 1;
    end else begin
      m_cyc++;
      if (st) m_stl++;
      if (b && z) m_br++;
      if (ev) begin
        m_ret++;
        if (store) exp_q.push_back('{seq: SEQ_W'(m_seq), dest: d, data: dat});
        else begin
          m_drp++;
          m_ovf = 1;
        end
        m_seq = (m_seq + 1) % (1 << SEQ_W);
      end
    end
    #1;
    check_state();
  endtask

  // monitor: compares the presented head with the oldest expected entry, pops on handshake
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (exp_q.size() == 0) check("idle_valid", {31'd0, op_trace_valid}, 32'd0);
      else begin
        check("head_valid", {31'd0, op_trace_valid}, 32'd1);
        check("head_seq", {16'd0, op_trace_seq}, {16'd0, exp_q[0].seq});
        check("head_dest", {27'd0, op_trace_dest}, {27'd0, exp_q[0].dest});
        check("head_data", op_trace_data, exp_q[0].data);
        if (ip_trace_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    check("rst_valid", {31'd0, op_trace_valid}, 32'd0);
    check("rst_seq", {16'd0, op_trace_seq}, 32'd0);
    check("rst_data", op_trace_data, 32'd0);
    check_state();
    @(posedge clock); #1; reset = 0;
    // write to $0 is not an event
    step(.we(1), .d(5'd0), .dat(32'hDEAD), .rdy(1));
    check("r0_retire", op_retire_count, 32'd0);
    check("r0_valid", {31'd0, op_trace_valid}, 32'd0);
    // three events drained immediately
    step(.we(1), .d(5'd1), .dat(32'h11), .rdy(1));
    check("ev1_valid", {31'd0, op_trace_valid}, 32'd1);
    check("ev1_seq", {16'd0, op_trace_seq}, 32'd0);
    check("ev1_data", op_trace_data, 32'h11);
    step(.we(1), .d(5'd2), .dat(32'h22), .rdy(1));
    step(.we(1), .d(5'd3), .dat(32'h33), .rdy(1));
    step(.rdy(1));
    check("t1_fill", {{(32-FW){1'b0}}, op_fill}, 32'd0);
    // overflow with consumer stalled
    step(.clr(1));
    for (int i = 0; i < DEPTH + 2; i++) step(.we(1), .d(5'(i + 1)), .dat($urandom));
    check("ovf_fill", {{(32-FW){1'b0}}, op_fill}, DEPTH);
    check("ovf_drop", op_drop_count, 32'd2);
    check("ovf_flag", {31'd0, op_overflow}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step(.rdy(1));
    step(.we(1), .d(5'd5), .dat(32'h5555));
    check("seq_gap", {16'd0, op_trace_seq}, 32'd10);
    // full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH - 1; i++) step(.we(1), .d(5'd6), .dat($urandom));
    check("full_fill", {{(32-FW){1'b0}}, op_fill}, DEPTH);
    step(.we(1), .d(5'd9), .dat(32'hABCD), .rdy(1));
    check("pp_fill", {{(32-FW){1'b0}}, op_fill}, DEPTH);
    check("pp_drop", op_drop_count, 32'd2);
    for (int i = 0; i < 3; i++) step(.rdy(1));
    // asynchronous reset mid-drain
    ip_trace_ready = 1;
    #2 reset = 1;
    #1;
    check("arst_valid", {31'd0, op_trace_valid}, 32'd0);
    check("arst_fill", {{(32-FW){1'b0}}, op_fill}, 32'd0);
    check("arst_cycle", op_cycle_count, 32'd0);
    check("arst_ovf", {31'd0, op_overflow}, 32'd0);
    model_reset();
    @(posedge clock); #1; reset = 0;
    // counter scenario: clear is cycle 1, stall on 3..5, branch&zero on 7
    step(.clr(1));
    for (int c = 2; c <= 10; c++) step(.st(c >= 3 && c <= 5), .b(c == 7 || c == 8), .z(c == 7));
    check("cnt_cycle", op_cycle_count, 32'd10);
    check("cnt_stall", op_stall_count, 32'd3);
    check("cnt_branch", op_branch_count, 32'd1);
    // clear concurrent with an event
    for (int i = 0; i < DEPTH + 1; i++) step(.we(1), .d(5'd7), .dat($urandom), .st(1));
    step(.we(1), .d(5'd8), .dat(32'h77), .st(1), .b(1), .z(1), .clr(1));
    check("clr_retire", op_retire_count, 32'd0);
    check("clr_stall", op_stall_count, 32'd0);
    check("clr_branch", op_branch_count, 32'd0);
    check("clr_drop", op_drop_count, 32'd0);
    check("clr_cycle", op_cycle_count, 32'd1);
    check("clr_valid", {31'd0, op_trace_valid}, 32'd0);
    check("clr_ovf", {31'd0, op_overflow}, 32'd0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(.we($urandom_range(9) < 7), .d(5'($urandom_range(31))), .dat($urandom),
           .rdy($urandom_range(1) == 1), .st($urandom_range(3) == 0), .b($urandom_range(1) == 1),
           .z($urandom_range(1) == 1), .clr($urandom_range(63) == 0));
    for (int i = 0; i < DEPTH + 1; i++) step(.rdy(1));
    check("final_valid", {31'd0, op_trace_valid}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
